// File: rtl/dbgreg_mailbox_if.sv
// CPU-side register bus of the debug mailbox.
// Handshake: the master raises wen or ren with addr/wdata stable and holds them
// until ready; ready is a one-cycle acknowledge in the cycle after the request
// is first seen, and rdata is meaningful only while ready=1 (0 otherwise).
interface dbgreg_mailbox_if;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ready;

  modport master (output addr, output wdata, output wen, output ren,
                  input rdata, input ready);
  modport slave  (input addr, input wdata, input wen, input ren,
                  output rdata, output ready);
endinterface

// File: rtl/dbgreg_mailbox.sv
// JTAG debug-register mailbox: DR data words queue into an RX FIFO for the CPU,
// DR command words land in a CMD register, and the CPU returns words via TXDATA.
module dbgreg_mailbox #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dbgreg_in,
  input  logic              dbgreg_sel,
  input  logic              dbgreg_strobe,
  output logic [31:0]       dbgreg_out,
  dbgreg_mailbox_if.slave   bus,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic          overflow, overflow_n;
  logic          cmd_valid, cmd_valid_n;
  logic          irq_en, irq_en_n;
  logic [31:0]   cmd, cmd_n;
  logic [31:0]   tx_n;
  logic          ready_q, ready_n;
  logic          irq_n;

  logic          empty, full;
  logic          do_wr, do_rd, push_req, push, pop, cmd_ld;
  logic [1:0]    reg_sel;
  logic [31:0]   status, rd_word;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[1:0];

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign reg_sel = bus.addr[3:2];
  assign status  = {15'd0, irq_en, 4'd0, cmd_valid, overflow, full, empty, 3'd0, 5'(count)};

  // Register side effects commit on the edge that closes the ready cycle.
  assign do_wr    = ready_q & bus.wen;
  assign do_rd    = ready_q & bus.ren & ~bus.wen;
  assign pop      = do_rd & (reg_sel == 2'd0) & ~empty;
  assign push_req = dbgreg_strobe & ~dbgreg_sel;
  assign push     = push_req & (~full | pop);
  assign cmd_ld   = dbgreg_strobe & dbgreg_sel;

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      2'd0: rd_word = empty ? '0 : mem[rd_ptr];
      2'd1: rd_word = status;
      2'd2: rd_word = dbgreg_out;
      2'd3: rd_word = cmd;
    endcase
  end

  assign bus.rdata = do_rd ? rd_word : '0;
  assign bus.ready = ready_q;

  always_comb begin
    ready_n     = (bus.wen | bus.ren) & ~ready_q;
    wr_ptr_n    = push ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_n    = pop  ? rd_ptr + AW'(1) : rd_ptr;
    count_n     = count + CW'(push) - CW'(pop);
    overflow_n  = overflow;
    cmd_valid_n = cmd_valid;
    irq_en_n    = irq_en;
    cmd_n       = cmd;
    tx_n        = dbgreg_out;

    if (do_wr) begin
      case (reg_sel)
        2'd1: begin
          if (bus.wdata[10]) overflow_n  = 1'b0;
          if (bus.wdata[11]) cmd_valid_n = 1'b0;
          irq_en_n = bus.wdata[16];
        end
        2'd2: tx_n = bus.wdata;
        2'd3: begin
          cmd_n       = '0;
          cmd_valid_n = 1'b0;
        end
        default: ;
      endcase
    end

    // Debugger-side events are applied last so a same-cycle clear loses.
    if (push_req & full & ~pop) overflow_n = 1'b1;
    if (cmd_ld) begin
      cmd_n       = dbgreg_in;
      cmd_valid_n = 1'b1;
    end

    irq_n = irq_en_n & ((count_n != '0) | overflow_n | cmd_valid_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      cmd_valid  <= 1'b0;
      irq_en     <= 1'b0;
      cmd        <= '0;
      dbgreg_out <= '0;
      ready_q    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      overflow   <= overflow_n;
      cmd_valid  <= cmd_valid_n;
      irq_en     <= irq_en_n;
      cmd        <= cmd_n;
      dbgreg_out <= tx_n;
      ready_q    <= ready_n;
      irq        <= irq_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= dbgreg_in;
  end

endmodule

// File: tb/tb_dbgreg_mailbox.sv
// Self-checking bench for dbgreg_mailbox: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based mailbox model.
module tb_dbgreg_mailbox;
  localparam int DEPTH = 4;

  localparam int OP_S0 = 0;
  localparam int OP_S1 = 1;
  localparam int OP_RD = 2;
  localparam int OP_WR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dbgreg_in = '0;
  logic        dbgreg_sel = 1'b0;
  logic        dbgreg_strobe = 1'b0;
  logic [31:0] dbgreg_out;
  logic        irq;

  dbgreg_mailbox_if bus_if();

  dbgreg_mailbox #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .dbgreg_in     (dbgreg_in),
    .dbgreg_sel    (dbgreg_sel),
    .dbgreg_strobe (dbgreg_strobe),
    .dbgreg_out    (dbgreg_out),
    .bus           (bus_if),
    .irq           (irq)
  );

  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic        m_ovf, m_cv, m_ien;
  logic [31:0] m_tx, m_cmd;

  task automatic model_clear();
    m_q.delete();
    m_ovf = 0; m_cv = 0; m_ien = 0; m_tx = '0; m_cmd = '0;
  endtask

  function automatic logic [31:0] m_status();
    return {15'd0, m_ien, 4'd0, m_cv, m_ovf, (m_q.size() == DEPTH),
            (m_q.size() == 0), 3'd0, 5'(m_q.size())};
  endfunction

  function automatic logic m_irq();
    return m_ien & ((m_q.size() != 0) | m_ovf | m_cv);
  endfunction

  task automatic model_step(input logic is_rd, input logic is_wr, input logic [3:0] a,
                            input logic [31:0] wd, input logic st_en, input logic st_sel,
                            input logic [31:0] st_d, output logic [31:0] exp);
    logic full_pre, pop, ovf_set;
    exp = '0;
    full_pre = (m_q.size() == DEPTH);
    if (is_rd) begin
      case (a[3:2])
        2'd0: exp = (m_q.size() > 0) ? m_q[0] : 32'd0;
        2'd1: exp = m_status();
        2'd2: exp = m_tx;
        2'd3: exp = m_cmd;
      endcase
    end
    pop = is_rd && (a[3:2] == 2'd0) && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    ovf_set = 0;
    if (st_en && !st_sel) begin
      if (!full_pre || pop) m_q.push_back(st_d);
      else ovf_set = 1;
    end
    if (is_wr) begin
      case (a[3:2])
        2'd1: begin
          if (wd[10]) m_ovf = 0;
          if (wd[11]) m_cv = 0;
          m_ien = wd[16];
        end
        2'd2: m_tx = wd;
        2'd3: begin m_cmd = '0; m_cv = 0; end
        default: ;
      endcase
    end
    if (ovf_set) m_ovf = 1;
    if (st_en && st_sel) begin m_cmd = st_d; m_cv = 1; end
  endtask

  // ---------------- drivers (start and end 1 time unit after posedge) ----------------
  task automatic do_reset();
    rst = 1;
    bus_if.wen = 0; bus_if.ren = 0; bus_if.addr = '0; bus_if.wdata = '0;
    dbgreg_strobe = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic do_strobe(input logic sel, input logic [31:0] d);
    dbgreg_sel = sel; dbgreg_in = d; dbgreg_strobe = 1;
    @(posedge clk);
    #1 dbgreg_strobe = 0;
  endtask

  task automatic bus_xfer(input logic is_wr, input logic [3:0] a, input logic [31:0] wd,
                          input logic st_en, input logic st_sel, input logic [31:0] st_d,
                          output logic [31:0] rd);
    int lat;
    lat = -1;
    rd = '0;
    bus_if.addr = a; bus_if.wdata = wd; bus_if.wen = is_wr; bus_if.ren = !is_wr;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.ready) begin lat = i; break; end
    end
    check("ready_latency", lat, 1);
    if (lat >= 0) begin
      rd = bus_if.rdata;
      if (st_en) begin dbgreg_sel = st_sel; dbgreg_in = st_d; dbgreg_strobe = 1; end
    end
    @(posedge clk);
    #1;
    bus_if.wen = 0; bus_if.ren = 0; dbgreg_strobe = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input int op, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] e);
    vq.push_back('{op: op, addr: a, data: d, exp: e});
  endtask

  initial begin
    logic [31:0] rd, exp;
    logic        is_wr, st_en, st_sel;
    logic [31:0] st_d, wd;
    logic [3:0]  a;
    int          kind;

    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_ready", {31'd0, bus_if.ready}, 32'd0);
    check("rst_rdata", bus_if.rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_dbgreg_out", dbgreg_out, 32'd0);
    @(posedge clk); #1;
    bus_xfer(0, 4'h4, '0, 0, 0, '0, rd);
    check("rst_status", rd, 32'h0000_0100);

    add_vec(OP_S0, 4'h0, 32'h1111_1111, '0);
    add_vec(OP_S0, 4'h0, 32'h2222_2222, '0);
    add_vec(OP_S0, 4'h0, 32'h3333_3333, '0);
    add_vec(OP_RD, 4'h4, '0, 32'h0000_0003);
    add_vec(OP_RD, 4'h0, '0, 32'h1111_1111);
    add_vec(OP_RD, 4'h0, '0, 32'h2222_2222);
    add_vec(OP_RD, 4'h0, '0, 32'h3333_3333);
    add_vec(OP_RD, 4'h0, '0, 32'h0000_0000);
    add_vec(OP_RD, 4'h4, '0, 32'h0000_0100);
    for (int i = 0; i < 5; i++) add_vec(OP_S0, 4'h0, 32'hA0 + 32'(i), '0);
    add_vec(OP_RD, 4'h4, '0, 32'h0000_0604);
    for (int i = 0; i < 4; i++) add_vec(OP_RD, 4'h0, '0, 32'hA0 + 32'(i));
    add_vec(OP_RD, 4'h4, '0, 32'h0000_0500);
    add_vec(OP_WR, 4'h4, 32'h0000_0400, '0);
    add_vec(OP_RD, 4'h4, '0, 32'h0000_0100);
    add_vec(OP_S1, 4'h0, 32'hDEAD_BEEF, '0);
    add_vec(OP_RD, 4'hC, '0, 32'hDEAD_BEEF);
    add_vec(OP_RD, 4'h4, '0, 32'h0000_0900);
    add_vec(OP_WR, 4'h4, 32'h0001_0000, '0);
    add_vec(OP_RD, 4'h7, '0, 32'h0001_0900);
    add_vec(OP_WR, 4'hC, 32'h1234_5678, '0);
    add_vec(OP_RD, 4'hC, '0, 32'h0000_0000);
    add_vec(OP_RD, 4'h4, '0, 32'h0001_0100);
    add_vec(OP_WR, 4'h8, 32'hCAFE_F00D, '0);
    add_vec(OP_RD, 4'hB, '0, 32'hCAFE_F00D);
    add_vec(OP_WR, 4'h4, 32'h0000_0000, '0);

    foreach (vq[i]) begin
      case (vq[i].op)
        OP_S0: do_strobe(0, vq[i].data);
        OP_S1: do_strobe(1, vq[i].data);
        OP_RD: begin
          bus_xfer(0, vq[i].addr, '0, 0, 0, '0, rd);
          check($sformatf("vec%0d_rd", i), rd, vq[i].exp);
        end
        default: bus_xfer(1, vq[i].addr, vq[i].data, 0, 0, '0, rd);
      endcase
    end

    // Push coincident with pop on a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) do_strobe(0, 32'hC0 + 32'(i));
    bus_xfer(0, 4'h0, '0, 1, 0, 32'hB0, rd);
    check("fullpop_head", rd, 32'hC0);
    bus_xfer(0, 4'h4, '0, 0, 0, '0, rd);
    check("fullpop_status", rd, 32'h0000_0204);
    for (int i = 1; i < 4; i++) begin
      bus_xfer(0, 4'h0, '0, 0, 0, '0, rd);
      check("fullpop_drain", rd, 32'hC0 + 32'(i));
    end
    bus_xfer(0, 4'h0, '0, 0, 0, '0, rd);
    check("fullpop_tail", rd, 32'hB0);

    // Interrupt on command arrival and its clear
    do_reset();
    bus_xfer(1, 4'h4, 32'h0001_0000, 0, 0, '0, rd);
    check("irq_idle", {31'd0, irq}, 32'd0);
    do_strobe(1, 32'hDEAD_BEEF);
    check("irq_cmd", {31'd0, irq}, 32'd1);
    bus_xfer(0, 4'h4, '0, 0, 0, '0, rd);
    check("irq_cmd_status", rd, 32'h0001_0900);
    bus_xfer(1, 4'hC, 32'hFFFF_FFFF, 0, 0, '0, rd);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // TXDATA write then reset during an open read
    bus_xfer(1, 4'h8, 32'hCAFE_F00D, 0, 0, '0, rd);
    check("tx_visible", dbgreg_out, 32'hCAFE_F00D);
    bus_if.addr = 4'h8; bus_if.ren = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_abort_ready", {31'd0, bus_if.ready}, 32'd0);
    check("rst_abort_txd", dbgreg_out, 32'd0);
    @(negedge clk);
    check("rst_abort_ready2", {31'd0, bus_if.ready}, 32'd0);
    @(posedge clk); #1;
    bus_if.ren = 0; rst = 0;
    @(negedge clk);
    check("rst_abort_after", {31'd0, bus_if.ready}, 32'd0);
    @(posedge clk); #1;

    // Held read request yields one ready every other cycle
    bus_if.addr = 4'h4; bus_if.ren = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("held_ready_c%0d", c), {31'd0, bus_if.ready}, (c == 2 || c == 4) ? 32'd1 : 32'd0);
      if (c == 1) check("held_rdata_idle", bus_if.rdata, 32'd0);
      if (c == 5) bus_if.ren = 0;
    end
    @(posedge clk); #1;

    // Same-cycle W1C versus set: set wins
    do_reset();
    for (int i = 0; i < 4; i++) do_strobe(0, 32'hD0 + 32'(i));
    bus_xfer(1, 4'h4, 32'h0000_0400, 1, 0, 32'hEE, rd);
    bus_xfer(0, 4'h4, '0, 0, 0, '0, rd);
    check("w1c_ovf_set_wins", rd, 32'h0000_0604);
    bus_xfer(1, 4'h4, 32'h0000_0800, 1, 1, 32'h1234, rd);
    bus_xfer(0, 4'h4, '0, 0, 0, '0, rd);
    check("w1c_cv_set_wins", rd, 32'h0000_0E04);
    bus_xfer(0, 4'hC, '0, 0, 0, '0, rd);
    check("w1c_cmd", rd, 32'h0000_1234);

    // Random traffic against the model
    do_reset();
    model_clear();
    for (int i = 0; i < 300; i++) begin
      kind   = $urandom_range(0, 2);
      st_en  = 1'($urandom_range(0, 1));
      st_sel = ($urandom_range(0, 3) == 0);
      st_d   = $urandom;
      a      = 4'($urandom_range(0, 15));
      wd     = $urandom;
      if (kind == 0) begin
        do_strobe(st_sel, st_d);
        model_step(0, 0, a, wd, 1, st_sel, st_d, exp);
      end else begin
        is_wr = (kind == 2);
        bus_xfer(is_wr, a, wd, st_en, st_sel, st_d, rd);
        model_step(!is_wr, is_wr, a, wd, st_en, st_sel, st_d, exp);
        if (!is_wr) check($sformatf("rand%0d_rd", i), rd, exp);
      end
      check($sformatf("rand%0d_irq", i), {31'd0, irq}, {31'd0, m_irq()});
      check($sformatf("rand%0d_txd", i), dbgreg_out, m_tx);
    end
    bus_xfer(0, 4'h4, '0, 0, 0, '0, rd);
    check("rand_final_status", rd, m_status());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbgreg_mailbox.md
DBGREG_MAILBOX -- requirements
Module: dbgreg_mailbox

Interface
REQ-001 Parameter: DEPTH, 4, RX FIFO depth in 32-bit words; power of two, 2..16.
REQ-002 clk  in  1  system clock (48 MHz SoC clock); all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 dbgreg_in  in  32  completed JTAG DR word.
REQ-005 dbgreg_sel  in  1  DR select: 0 = data (IR 0x32), 1 = command (IR 0x38).
REQ-006 dbgreg_strobe  in  1  single-cycle pulse; dbgreg_in/dbgreg_sel valid this cycle.
REQ-007 dbgreg_out  out  32  word presented to the JTAG capture path.
REQ-008 addr  in  4  CPU register address (byte offset, bits [1:0] ignored).
REQ-009 wdata  in  32  CPU write data.
REQ-010 wen  in  1  CPU write request, held until ready.
REQ-011 ren  in  1  CPU read request, held until ready.
REQ-012 rdata  out  32  CPU read data, valid only while ready=1, else 0.
REQ-013 ready  out  1  one-cycle acknowledge.
REQ-014 irq  out  1  level interrupt.

Function
REQ-015 Bus: a request (wen or ren) seen with ready=0 in cycle N shall give ready=1 in cycle N+1 exactly; ready shall be 0 in N+2 even if the request stays high. A new transaction may then start in N+2.
REQ-016 wen and ren both high: treat as a write only.
REQ-017 Register map: 0x0 RXDATA (R, pops FIFO), 0x4 STATUS (R; W1C), 0x8 TXDATA (R/W), 0xC CMD (R; W clears).
REQ-018 STATUS[4:0] = count, [8] empty, [9] full, [10] overflow (sticky), [11] cmd_valid, [16] irq_en (R/W).
REQ-019 Strobe with sel=0: push dbgreg_in into the FIFO if not full. If full, drop the word and set overflow.
REQ-020 Strobe with sel=1: load CMD with dbgreg_in and set cmd_valid. The FIFO is unaffected. An earlier unread CMD is overwritten with no error.
REQ-021 RXDATA read: rdata = head word, and pop in the same cycle as ready. If empty: rdata = 0, no pointer change, no flag change.
REQ-022 Push and pop in the same cycle: both occur and count is unchanged. This holds when full; the push is accepted and overflow is not set.
REQ-023 Pointers shall be log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits, 0..DEPTH.
REQ-024 STATUS write: wdata[10]=1 clears overflow, wdata[11]=1 clears cmd_valid, wdata[16] loads irq_en.
REQ-025 A strobe setting a flag in the same cycle as a W1C of that flag: set wins.
REQ-026 CMD write (any data): clears CMD to 0 and cmd_valid.
REQ-027 TXDATA write: dbgreg_out <= wdata, visible the cycle after ready. TXDATA read returns dbgreg_out.
REQ-028 irq shall be registered as irq_en & (!empty | overflow | cmd_valid), one cycle after the causing event.
REQ-029 Unmapped addresses: read 0, writes ignored, ready still given.

Reset
REQ-030 On rst, the block shall reset to:
  - FIFO empty; pointers and count 0.
  - overflow, cmd_valid and irq_en all 0.
  - CMD and dbgreg_out 0.
  - ready, rdata and irq all 0.
REQ-031 rst during an open bus transaction aborts it; no ready is issued for it.
REQ-032 A strobe coincident with rst is discarded.
REQ-033 FIFO storage contents need no reset.

Verification
REQ-034 Reset, then strobe sel=0 with 0x11111111, 0x22222222, 0x33333333; read 0x4 -> count=3, empty=0. Read 0x0 three times -> 0x11111111, 0x22222222, 0x33333333, in order. Fourth read -> 0, STATUS empty=1.
REQ-035 DEPTH=4: five sel=0 strobes 0xA0..0xA4 -> full=1, overflow=1. Reads return 0xA0..0xA3. Write 0x4 with 0x400 -> overflow=0.
REQ-036 FIFO full, strobe 0xB0 in the same cycle as RXDATA pop -> head popped, 0xB0 queued at tail, count stays 4, overflow stays 0.
REQ-037 Strobe sel=1 with 0xDEADBEEF -> CMD=0xDEADBEEF, cmd_valid=1, FIFO count 0. Set irq_en -> irq=1 next cycle. Write 0xC -> CMD=0, irq=0.
REQ-038 Write 0x8 with 0xCAFEF00D -> dbgreg_out=0xCAFEF00D the next cycle. Read 0x8 returns it. Assert rst mid-read -> no ready, dbgreg_out=0.
REQ-039 Hold ren high 5 cycles on 0x4 -> ready pulses once in cycle 2, again in cycle 4. Write-1-to-clear of overflow in the same cycle as an overflowing strobe -> overflow remains 1.
